// File: rtl/imem_program_loader.sv
// Instruction-memory program loader: LEN_LO, LEN_HI, then 4*N little-endian bytes -> N words.
// Latency: imem_we pulses the cycle after a word's 4th byte; peak rate is 4 bytes per 5 cycles.
// Backpressure: byte_ready is low outside LEN_LO/LEN_HI/DATA, so it drops for the WRITE cycle.
// Optional: define LOADER_TIMEOUT_EN to abort to ERROR after TIMEOUT_CYCLES without a byte.
module imem_program_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic [15:0]           word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  // Largest legal program length: one word per memory location.
  localparam int unsigned CAPACITY = 32'd1 << ADDR_WIDTH;

  state_t                  state;
  state_t                  state_next;
  logic [15:0]             n_words;
  logic [15:0]             n_words_in;
  logic [1:0]              byte_cnt;
  logic [23:0]             shift;
  logic [ADDR_WIDTH-1:0]   index;
  logic                    accept;
  logic                    len_bad;
  logic                    timeout_hit;

  // The loader only takes bytes while it is parsing the length or collecting word data.
  assign byte_ready = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
  assign accept     = byte_valid && byte_ready;

  // Full length as it will be once the LEN_HI byte lands; used to reject bad lengths early.
  assign n_words_in = {byte_data, n_words[7:0]};
  assign len_bad    = (n_words_in == 16'd0) || (32'(n_words_in) > CAPACITY);

`ifdef LOADER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] idle_cnt;

  // Idle counter: restarts on every accepted byte and whenever the state changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (!byte_ready || accept || (state_next != state)) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  // The TIMEOUT_CYCLES-th consecutive idle cycle in a byte-taking state aborts the session.
  assign timeout_hit = byte_ready && !accept && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;

  // TIMEOUT_CYCLES only sizes the optional idle counter; this keeps it referenced without it.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_unused
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    state_next = state;
    imem_we    = 1'b0;
    core_reset = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        busy = 1'b1;
        if (accept) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        busy = 1'b1;
        if (accept) state_next = len_bad ? S_ERROR : S_DATA;
      end
      S_DATA: begin
        busy = 1'b1;
        if (accept && (byte_cnt == 2'd3)) state_next = S_WRITE;
      end
      S_WRITE: begin
        busy    = 1'b1;
        imem_we = 1'b1;
        state_next = ((word_count + 16'd1) == n_words) ? S_DONE : S_DATA;
      end
      S_DONE: begin
        done       = 1'b1;
        core_reset = 1'b0;
        if (start) state_next = S_LEN_LO;
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) state_next = S_LEN_LO;
      end
      default: state_next = S_IDLE;
    endcase
    if (timeout_hit) state_next = S_ERROR;
  end

  // Datapath: length capture, word assembly, write address/data staging and word counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_words    <= '0;
      byte_cnt   <= '0;
      shift      <= '0;
      index      <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) word_count <= '0;
        end
        S_LEN_LO: begin
          if (accept) n_words[7:0] <= byte_data;
        end
        S_LEN_HI: begin
          if (accept) begin
            n_words[15:8] <= byte_data;
            byte_cnt      <= '0;
            index         <= '0;
          end
        end
        S_DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {byte_data, shift[23:8]};
            // Stage address and word so they stay stable through WRITE and hold afterwards.
            if (byte_cnt == 2'd3) begin
              imem_addr  <= index;
              imem_wdata <= {byte_data, shift};
            end
          end
        end
        S_WRITE: begin
          word_count <= word_count + 16'd1;
          index      <= index + ADDR_WIDTH'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
